uart_tx_feeder: RTL and testbench
=================================

// Module: uart_tx_feeder
// PURPOSE
//  Byte buffer and launch sequencer directly upstream of the UART TX core (controller + serializer).
//  Accepts bytes from the system side into a DEPTH-entry FIFO.
//  Presents them one at a time on P_DATA with a 1-cycle Data_Valid pulse, only while the TX core is idle.
//  Holds P_DATA stable for the whole frame.
// PARAMETERS
//  DATA_WIDTH   8   byte width; matches TX core parallel input
//  DEPTH        16  FIFO entries; power of 2, >=2
//  ACK_TIMEOUT  4   max cycles to wait for busy to rise after Data_Valid (>=2)
// PORTS
//  clk         in   1           system clock, rising edge
//  rst         in   1           asynchronous reset, active-low
//  wr_en       in   1           push wr_data when high and full==0
//  wr_data     in   DATA_WIDTH  byte to transmit
//  full        out  1           FIFO holds DEPTH entries
//  empty       out  1           FIFO holds 0 entries
//  overflow    out  1           1-cycle pulse: wr_en while full, byte dropped
//  busy        in   1           TX core busy (high START..STOP)
//  Data_Valid  out  1           1-cycle launch pulse to TX core
//  P_DATA      out  DATA_WIDTH  byte of the current frame, registered
//  tx_err      out  1           1-cycle pulse: busy did not rise within ACK_TIMEOUT
// BEHAVIOUR
//  Reset (rst=0, async): FIFO emptied (ptrs/count=0), state=IDLE.
//   Outputs: full=0, empty=1, overflow=0, Data_Valid=0, P_DATA=0, tx_err=0.
//  FIFO: count width $clog2(DEPTH)+1; ptrs wrap modulo DEPTH.
//   full/empty decoded from registered count.
//   Write accepted iff wr_en && !full; a pop in the same cycle does not free space for that write.
//   Simultaneous accepted write + pop: count unchanged.
//  FSM (registered; Data_Valid = state==LAUNCH):
//   IDLE      : !empty && !busy -> LAUNCH; on this edge P_DATA<=mem[rd_ptr], rd_ptr++, count--.
//   LAUNCH    : Data_Valid=1 for exactly 1 cycle -> WAIT_ACK; timer cleared.
//   WAIT_ACK  : busy=1 -> WAIT_DONE.
//               Timer reaches ACK_TIMEOUT-1 with busy=0 -> tx_err pulse, -> IDLE; byte discarded, not relaunched.
//   WAIT_DONE : busy=0 -> IDLE.
//  Latency: wr_en at edge k into empty FIFO with busy=0 -> Data_Valid high in cycle k+1..k+2.
//  P_DATA changes only on the IDLE->LAUNCH edge; stable from launch through busy falling.
//  Next launch no earlier than 1 cycle after busy falls (TX core returns to IDLE: line high >=1 extra bit time).
//  Back-to-back via the TX core's STOP-state Data_Valid path is not used.
//  busy high while in IDLE (core started elsewhere): no launch until busy=0.
//  Reset mid-frame: FSM and FIFO cleared immediately; in-flight frame is the TX core's responsibility.
// CONFIGURATION
//  UART_TX_FEEDER_LEVEL_EN defined:
//   adds outputs fifo_level [$clog2(DEPTH):0] (= count, reset 0) and almost_full (count >= DEPTH-2, reset 0).
//  Not defined: ports absent, no extra logic; all other behaviour identical.
// STRUCTURE
//  uart_tx_pkg: FSM state localparams (IDLE=2'd0, LAUNCH=2'd1, WAIT_ACK=2'd2, WAIT_DONE=2'd3) and default DATA_WIDTH.
//  Sub-module uart_sync_fifo: storage, pointers, count, full/empty.
//   Ports push/pop/din/dout/full/empty/count.
//  Top holds FSM, ACK timer, P_DATA register, overflow/tx_err pulses.
// TESTING
//  1. Reset, then wr_en one cycle with 8'hA5, busy=0
//     -> Data_Valid 1 cycle, P_DATA=8'hA5; empty=1 after pop.
//  2. Push 3'h{11,22,33}; TX model raises busy 1 cycle after Data_Valid, holds it 11 cycles
//     -> three launches in order; each Data_Valid >=1 cycle after busy fell; P_DATA stable per frame.
//  3. Hold busy=1; push 16 bytes then a 17th
//     -> full=1 after 16th; overflow pulse on 17th; count stays 16; 17th never transmitted.
//  4. busy tied 0 after launch of 8'h5A
//     -> tx_err pulse exactly ACK_TIMEOUT cycles after entering WAIT_ACK; FSM IDLE; next byte launches.
//  5. Assert rst mid-WAIT_DONE with 5 bytes queued
//     -> Data_Valid=0, P_DATA=0, empty=1 async; no launch after release until new write.
//  6. With UART_TX_FEEDER_LEVEL_EN: push 14 bytes, busy=1
//     -> fifo_level=14, almost_full=1; one pop -> 13, almost_full=0.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared FSM encodings and defaults for the UART TX feeder
package uart_tx_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_ACK  = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - single-clock FIFO with registered occupancy count
module uart_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           count
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // full is taken from the registered count, so a same-cycle pop never frees room for this push
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - byte FIFO and launch sequencer ahead of the UART TX core
// Optional UART_TX_FEEDER_LEVEL_EN adds fifo_level and almost_full outputs.
module uart_tx_feeder
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  busy,
  output logic                  Data_Valid,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  tx_err
`ifdef UART_TX_FEEDER_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   almost_full
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

  logic [1:0]            state;
  logic [TW-1:0]         timer;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic [CW-1:0]         fifo_count;
  logic                  launch_go;

  // Launch only from IDLE with the core quiet; the pop and the P_DATA load share this edge
  assign launch_go  = (state == IDLE) && !empty && !busy;
  assign Data_Valid = (state == LAUNCH);

  uart_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (launch_go),
    .din   (wr_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

`ifdef UART_TX_FEEDER_LEVEL_EN
  assign fifo_level  = fifo_count;
  assign almost_full = (fifo_count >= CW'(DEPTH - 2));
`else
  logic [CW-1:0] fifo_count_unused;
  assign fifo_count_unused = fifo_count;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      P_DATA   <= '0;
      tx_err   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_en && full;
      tx_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_go) begin
            state  <= LAUNCH;
            P_DATA <= fifo_dout;
          end
        end
        LAUNCH: begin
          state <= WAIT_ACK;
          timer <= '0;
        end
        WAIT_ACK: begin
          // A core that never acknowledges loses this byte; it is not relaunched
          if (busy) begin
            state <= WAIT_DONE;
          end else if (timer == TIMER_LAST) begin
            tx_err <= 1'b1;
            state  <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

  localparam int ACK_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy = 1'b0;
  logic       full, empty, overflow, Data_Valid, tx_err;
  logic [7:0] P_DATA;
`ifdef UART_TX_FEEDER_LEVEL_EN
  logic [4:0] fifo_level;
  logic       almost_full;
`endif

  int n_run  = 0;
  int n_fail = 0;

  uart_tx_feeder #(
    .DATA_WIDTH  (8),
    .DEPTH       (16),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .overflow   (overflow),
    .busy       (busy),
    .Data_Valid (Data_Valid),
    .P_DATA     (P_DATA),
    .tx_err     (tx_err)
`ifdef UART_TX_FEEDER_LEVEL_EN
    ,
    .fifo_level  (fifo_level),
    .almost_full (almost_full)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_launch(input logic [7:0] exp, input string tag);
    int n = 0;
    while (!Data_Valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_dv"}, 32'(Data_Valid), 32'd1);
    check({tag, "_pdata"}, 32'(P_DATA), 32'(exp));
  endtask

  // Core model: busy rises the cycle after Data_Valid and stays high 11 cycles
  task automatic run_frame(input logic [7:0] exp, input string tag);
    tick();
    check({tag, "_dv_one_cycle"}, 32'(Data_Valid), 32'd0);
    busy = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick();
      check({tag, "_hold"}, 32'({Data_Valid, P_DATA}), 32'({1'b0, exp}));
    end
    busy = 1'b0;
    tick();
    check({tag, "_gap"}, 32'(Data_Valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [7:0] t2 [3];
    int         seen;
    t2[0] = 8'h11;
    t2[1] = 8'h22;
    t2[2] = 8'h33;

    // reset state
    tick();
    check("rst_outputs", 32'({full, empty, overflow, Data_Valid, tx_err}), 32'b01000);
    check("rst_pdata", 32'(P_DATA), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // single byte
    push(8'hA5);
    check("t1_not_yet", 32'({Data_Valid, empty}), 32'b00);
    tick();
    check("t1_dv", 32'(Data_Valid), 32'd1);
    check("t1_pdata", 32'(P_DATA), 32'hA5);
    check("t1_empty", 32'(empty), 32'd1);
    run_frame(8'hA5, "t1");

    // three queued frames, released together
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(t2[i]);
      check("t2_blocked", 32'(Data_Valid), 32'd0);
    end
    busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_launch(t2[i], "t2");
      run_frame(t2[i], "t2");
    end
    check("t2_empty", 32'(empty), 32'd1);

    // fill and overflow
    busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_not_full", 32'(full), 32'd0);
      push(8'h40 + 8'(i));
    end
    check("t3_full", 32'({full, empty}), 32'b10);
`ifdef UART_TX_FEEDER_LEVEL_EN
    check("t3_level16", 32'(fifo_level), 32'd16);
`endif
    check("t3_no_ovf_yet", 32'(overflow), 32'd0);
    push(8'hEE);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_still_full", 32'(full), 32'd1);
    tick();
    check("t3_ovf_pulse", 32'(overflow), 32'd0);
    busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wait_launch(8'h40 + 8'(i), "t3");
      run_frame(8'h40 + 8'(i), "t3");
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Data_Valid) seen++;
    end
    check("t3_dropped_never_sent", 32'(seen), 32'd0);
    check("t3_empty", 32'(empty), 32'd1);

    // acknowledge timeout
    push(8'h5A);
    wait_launch(8'h5A, "t4");
    for (int i = 1; i <= ACK_TIMEOUT; i++) begin
      tick();
      wr_en   = (i == 1);
      wr_data = 8'h77;
      check("t4_no_err_early", 32'(tx_err), 32'd0);
    end
    wr_en = 1'b0;
    tick();
    check("t4_tx_err", 32'(tx_err), 32'd1);
    check("t4_idle", 32'(Data_Valid), 32'd0);
    tick();
    check("t4_err_pulse", 32'(tx_err), 32'd0);
    check("t4_next_dv", 32'(Data_Valid), 32'd1);
    check("t4_next_pdata", 32'(P_DATA), 32'h77);
    run_frame(8'h77, "t4");

    // reset in the middle of a frame
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push(8'h91 + 8'(i));
    end
    busy = 1'b0;
    wait_launch(8'h91, "t5");
    tick();
    busy = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    check("t5_async_dv", 32'(Data_Valid), 32'd0);
    check("t5_async_pdata", 32'(P_DATA), 32'h0);
    check("t5_async_empty", 32'({full, empty}), 32'b01);
    tick();
    rst  = 1'b1;
    busy = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (Data_Valid) seen++;
    end
    check("t5_no_launch", 32'(seen), 32'd0);
    push(8'h3C);
    wait_launch(8'h3C, "t5");
    run_frame(8'h3C, "t5");

`ifdef UART_TX_FEEDER_LEVEL_EN
    check("t6_level0", 32'({fifo_level, almost_full}), 32'd0);
    busy = 1'b1;
    for (int i = 0; i < 14; i++) begin
      push(8'hC0 + 8'(i));
    end
    check("t6_level14", 32'(fifo_level), 32'd14);
    check("t6_af1", 32'(almost_full), 32'd1);
    busy = 1'b0;
    tick();
    check("t6_pop_dv", 32'(Data_Valid), 32'd1);
    check("t6_level13", 32'(fifo_level), 32'd13);
    check("t6_af0", 32'(almost_full), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
